// File: rtl/riscv_pkg.sv
// Shared RV64I encoding definitions: instruction formats, encoder states and
// the major opcode constants used when packing instruction words.
package riscv_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_SB  = 3'd3,
        FMT_U   = 3'd4,
        FMT_UJ  = 3'd5,
        FMT_LI  = 3'd6,
        FMT_ILL = 3'd7
    } fmt_e;

    typedef enum logic {
        ST_IDLE,
        ST_SECOND
    } state_e;

    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_32     = 7'b0111011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] JALR      = 7'b1100111;

    localparam logic [2:0] F3_ADD    = 3'b000;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: turns a format plus raw fields into the instruction
// word(s) and flags requests whose immediate cannot be encoded.
module instr_pack
    import riscv_pkg::*;
#(
    parameter int CHECK_RANGE = 1,
    parameter int ENABLE_LI   = 1
) (
    input  fmt_e        fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word0,
    output logic [31:0] word1,
    output logic        two_word,
    output logic        bad
);

    logic signed [31:0] simm;
    logic        ok12, ok_sb, ok_uj, ok_u;
    logic [11:0] lo;
    logic [19:0] hi;

    assign simm  = $signed(imm);
    assign ok12  = (simm >= -32'sd2048) && (simm <= 32'sd2047);
    assign ok_sb = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !imm[0];
    assign ok_uj = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !imm[0];
    assign ok_u  = (imm[11:0] == 12'd0);

    // Adding 0x800 before taking the upper 20 bits only carries in imm[11],
    // which compensates for the sign-extended low part added by ADDIW.
    assign lo = imm[11:0];
    assign hi = imm[31:12] + {19'd0, imm[11]};

    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // case statement leaves a value unassigned and infers a latch.
        word0    = '0;
        word1    = '0;
        two_word = 1'b0;
        bad      = 1'b0;
        unique case (fmt)
            FMT_R:  word0 = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: begin
                word0 = {imm[11:0], rs1, funct3, rd, opcode};
                bad   = (CHECK_RANGE != 0) && !ok12;
            end
            FMT_S: begin
                word0 = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                bad   = (CHECK_RANGE != 0) && !ok12;
            end
            FMT_SB: begin
                word0 = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                bad   = (CHECK_RANGE != 0) && !ok_sb;
            end
            FMT_U: begin
                word0 = {imm[31:12], rd, opcode};
                bad   = (CHECK_RANGE != 0) && !ok_u;
            end
            FMT_UJ: begin
                word0 = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                bad   = (CHECK_RANGE != 0) && !ok_uj;
            end
            FMT_LI: begin
                if (ENABLE_LI == 0) begin
                    bad = 1'b1;
                end else if (ok12) begin
                    word0 = {imm[11:0], 5'd0, F3_ADD, rd, OP_IMM};
                end else begin
                    word0    = {hi, rd, LUI};
                    word1    = {lo, rd, F3_ADD, rd, OP_IMM_32};
                    two_word = (lo != 12'd0);
                end
            end
            default: bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// RV64I instruction encoder: accepts one request per handshake and emits one
// or two registered instruction words, pulsing err for unencodable requests.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int CHECK_RANGE = 1,
    parameter int ENABLE_LI   = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last,
    output logic        err
);

    state_e      state, state_nxt;
    logic [31:0] word0, word1, pend;
    logic        two_word, bad;
    logic        accept, out_fire;

    instr_pack #(
        .CHECK_RANGE(CHECK_RANGE),
        .ENABLE_LI  (ENABLE_LI)
    ) u_pack (
        .fmt     (fmt_e'(in_fmt)),
        .opcode  (in_opcode),
        .funct3  (in_funct3),
        .funct7  (in_funct7),
        .rd      (in_rd),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .imm     (in_imm),
        .word0   (word0),
        .word1   (word1),
        .two_word(two_word),
        .bad     (bad)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (accept && !bad && two_word) state_nxt = ST_SECOND;
            ST_SECOND: if (out_fire)                   state_nxt = ST_IDLE;
            default:                                   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        out_fire = out_valid && out_ready;
        in_ready = (state == ST_IDLE) && (!out_valid || (out_ready && out_last));
        accept   = in_valid && in_ready;
    end

    // Output register; in SECOND the held LUI is replaced by the ADDIW word
    // on the same edge that hands the LUI to the consumer.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: the pending word is reset too, so a reset mid-LI can never
        // leak a stale ADDIW after release.
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_last  <= 1'b0;
            err       <= 1'b0;
            pend      <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating
            // from pre-edge values regardless of statement order.
            err <= accept && bad;
            if (accept) begin
                out_valid <= !bad;
                if (!bad) begin
                    out_instr <= word0;
                    out_last  <= !two_word;
                    pend      <= word1;
                end
            end else if (state == ST_SECOND && out_fire) begin
                out_instr <= pend;
                out_last  <= 1'b1;
                out_valid <= 1'b1;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
